// File: rtl/ibert_stage_sequencer.sv
// I-BERT encoder run controller: walks a small per-stage config table and,
// for each enabled stage in index order, drives the shared address/requant
// buses, pulses that stage's start, and waits for done/error under a watchdog.
module ibert_stage_sequencer #(
  parameter int unsigned N_STAGES  = 4,
  parameter int unsigned TIMEOUT_W = 32,
  parameter int unsigned ADDR_W    = 64,
  localparam int unsigned SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_we,
  input  logic [SW-1:0]        i_cfg_idx,
  input  logic                 i_cfg_en,
  input  logic [ADDR_W-1:0]    i_cfg_addr_a,
  input  logic [ADDR_W-1:0]    i_cfg_addr_k,
  input  logic [ADDR_W-1:0]    i_cfg_addr_g,
  input  logic [31:0]          i_cfg_m_mult,
  input  logic [31:0]          i_cfg_m_g,
  input  logic [7:0]           i_cfg_e_mult,
  input  logic [7:0]           i_cfg_e_g,
  input  logic [TIMEOUT_W-1:0] i_timeout_cycles,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [1:0]           o_err_code,
  output logic [SW-1:0]        o_err_stage,
  output logic [SW-1:0]        o_cur_stage,
  output logic [N_STAGES-1:0]  o_stage_start,
  input  logic [N_STAGES-1:0]  i_stage_done,
  input  logic [N_STAGES-1:0]  i_stage_error,
  output logic [ADDR_W-1:0]    o_addr_a,
  output logic [ADDR_W-1:0]    o_addr_k,
  output logic [ADDR_W-1:0]    o_addr_g,
  output logic [31:0]          o_requant_m_mult,
  output logic [31:0]          o_requant_m_g,
  output logic [7:0]           o_requant_e_mult,
  output logic [7:0]           o_requant_e_g
);

  localparam logic [SW-1:0] LAST_IDX = SW'(N_STAGES - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_g;
    logic [31:0]       m_mult;
    logic [31:0]       m_g;
    logic [7:0]        e_mult;
    logic [7:0]        e_g;
  } payload_t;

  typedef struct packed {
    logic     en;
    payload_t pl;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_DONE, S_FAULT
  } state_t;

  state_t               r_state, w_state_nxt;
  entry_t               r_tbl [N_STAGES];
  payload_t             r_bus;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_busy, r_done, r_error;
  logic [1:0]           r_err_code;
  logic [SW-1:0]        r_err_stage, r_cur_stage;
  logic [N_STAGES-1:0]  r_stage_start;

  entry_t w_cur;
  logic   w_idle_like, w_last, w_wd_hit, w_cur_done, w_cur_err;
  logic   w_start_ok, w_issue, w_advance, w_finish, w_fault_err, w_fault_to, w_wd_inc;

  assign w_cur       = r_tbl[r_cur_stage];
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAULT);
  assign w_last      = (r_cur_stage == LAST_IDX);
  assign w_cur_done  = i_stage_done[r_cur_stage];
  assign w_cur_err   = i_stage_error[r_cur_stage];
  assign w_wd_hit    = (i_timeout_cycles != '0) &&
                       (r_wd == i_timeout_cycles - TIMEOUT_W'(1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_issue     = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_fault_err = 1'b0;
    w_fault_to  = 1'b0;
    w_wd_inc    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (i_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_cur.en) begin
          w_issue     = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_advance   = 1'b1;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_cur_err) begin
          w_fault_err = 1'b1;
          w_state_nxt = S_FAULT;
        end else if (w_cur_done) begin
          if (w_last) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = S_SCAN;
          end
        end else if (w_wd_hit) begin
          w_fault_to  = 1'b1;
          w_state_nxt = S_FAULT;
        end else begin
          w_wd_inc    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config table, shared buses, status and watchdog
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < N_STAGES; i++) r_tbl[i] <= '0;
      r_bus         <= '0;
      r_wd          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= 2'd0;
      r_err_stage   <= '0;
      r_cur_stage   <= '0;
      r_stage_start <= '0;
    end else begin
      r_stage_start <= '0;
      if (w_idle_like && i_cfg_we && (32'(i_cfg_idx) < N_STAGES)) begin
        r_tbl[i_cfg_idx] <= '{en: i_cfg_en,
                              pl: '{addr_a: i_cfg_addr_a, addr_k: i_cfg_addr_k,
                                    addr_g: i_cfg_addr_g, m_mult: i_cfg_m_mult,
                                    m_g: i_cfg_m_g, e_mult: i_cfg_e_mult,
                                    e_g: i_cfg_e_g}};
      end
      if (w_start_ok) begin
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_err_code  <= 2'd0;
        r_err_stage <= '0;
        r_cur_stage <= '0;
      end
      if (w_advance) r_cur_stage <= r_cur_stage + SW'(1);
      if (w_issue) begin
        r_bus         <= w_cur.pl;
        r_stage_start <= N_STAGES'(1) << r_cur_stage;
      end
      if (r_state == S_ISSUE)           r_wd <= '0;
      else if (w_wd_inc && r_wd != '1)  r_wd <= r_wd + TIMEOUT_W'(1);
      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_fault_err || w_fault_to) begin
        r_busy      <= 1'b0;
        r_error     <= 1'b1;
        r_err_code  <= w_fault_err ? 2'd1 : 2'd2;
        r_err_stage <= r_cur_stage;
      end
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_err_code       = r_err_code;
  assign o_err_stage      = r_err_stage;
  assign o_cur_stage      = r_cur_stage;
  assign o_stage_start    = r_stage_start;
  assign o_addr_a         = r_bus.addr_a;
  assign o_addr_k         = r_bus.addr_k;
  assign o_addr_g         = r_bus.addr_g;
  assign o_requant_m_mult = r_bus.m_mult;
  assign o_requant_m_g    = r_bus.m_g;
  assign o_requant_e_mult = r_bus.e_mult;
  assign o_requant_e_g    = r_bus.e_g;

endmodule

// File: tb/tb_ibert_stage_sequencer.sv
// Bench for ibert_stage_sequencer: directed vector table, hand sequences for
// watchdog timing / reset / mid-run writes, and randomized runs scored
// against an outcome model of the run rules.
module tb_ibert_stage_sequencer;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_idx = '0;
  logic          cfg_en = 1'b0;
  logic [AW-1:0] cfg_addr_a = '0, cfg_addr_k = '0, cfg_addr_g = '0;
  logic [31:0]   cfg_m_mult = '0, cfg_m_g = '0;
  logic [7:0]    cfg_e_mult = '0, cfg_e_g = '0;
  logic [TW-1:0] timeout_cycles = '0;
  logic          start = 1'b0;
  logic [N-1:0]  rsp_done = '0, rsp_err = '0;

  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [SW-1:0] err_stage, cur_stage;
  logic [N-1:0]  stage_start;
  logic [AW-1:0] addr_a, addr_k, addr_g;
  logic [31:0]   m_mult, m_g;
  logic [7:0]    e_mult, e_g;

  ibert_stage_sequencer #(.N_STAGES(N), .TIMEOUT_W(TW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_en(cfg_en),
    .i_cfg_addr_a(cfg_addr_a), .i_cfg_addr_k(cfg_addr_k), .i_cfg_addr_g(cfg_addr_g),
    .i_cfg_m_mult(cfg_m_mult), .i_cfg_m_g(cfg_m_g), .i_cfg_e_mult(cfg_e_mult),
    .i_cfg_e_g(cfg_e_g), .i_timeout_cycles(timeout_cycles), .i_start(start),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_code(err_code),
    .o_err_stage(err_stage), .o_cur_stage(cur_stage), .o_stage_start(stage_start),
    .i_stage_done(rsp_done), .i_stage_error(rsp_err),
    .o_addr_a(addr_a), .o_addr_k(addr_k), .o_addr_g(addr_g),
    .o_requant_m_mult(m_mult), .o_requant_m_g(m_g),
    .o_requant_e_mult(e_mult), .o_requant_e_g(e_g));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model of the table contents and stage behaviour (0 done, 1 error+done, 2 silent)
  bit          m_en   [N];
  logic [AW-1:0] m_addr [N];
  logic [31:0] m_mm   [N];
  int          mode   [N];
  int          lat    [N];
  int          cnt    [N];

  int          start_log [$];
  logic [AW-1:0] addr_log [$];
  logic [31:0] mm_log [$];
  bit          prev_start = 1'b0;

  int exp_q [$];
  bit exp_done, exp_err;
  int exp_code, exp_stage;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stage responders: answer lat cycles after their start pulse
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      rsp_done[i] = 1'b0;
      rsp_err[i]  = 1'b0;
      if (rst) cnt[i] = 0;
      else if (stage_start[i]) cnt[i] = lat[i];
      else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0 && mode[i] != 2) begin
          rsp_done[i] = 1'b1;
          rsp_err[i]  = (mode[i] == 1);
        end
      end
    end
  end

  // Log every start pulse with the bus contents visible alongside it
  always @(negedge clk) begin
    if (!rst && stage_start != '0) begin
      int idx;
      idx = 0;
      for (int i = 0; i < N; i++) if (stage_start[i]) idx = i;
      start_log.push_back(idx);
      addr_log.push_back(addr_a);
      mm_log.push_back(m_mult);
      check("start_onehot", 64'($countones(stage_start)), 64'(1));
      check("start_gap", 64'(prev_start), 64'(0));
    end
    prev_start = |stage_start;
  end

  task automatic write_entry(input int idx, input bit en, input bit upd);
    cfg_idx    = SW'(idx);
    cfg_en     = en;
    cfg_addr_a = {$urandom, $urandom};
    cfg_addr_k = {$urandom, $urandom};
    cfg_addr_g = {$urandom, $urandom};
    cfg_m_mult = $urandom;
    cfg_m_g    = $urandom;
    cfg_e_mult = 8'($urandom);
    cfg_e_g    = 8'($urandom);
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    if (upd) begin
      m_en[idx]   = en;
      m_addr[idx] = cfg_addr_a;
      m_mm[idx]   = cfg_m_mult;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 1'b0; m_addr[i] = '0; m_mm[i] = '0;
    end
  endtask

  // Outcome of a run from the rules: enabled stages in order, first fault stops it
  task automatic build_expect(input int tmo);
    exp_q.delete();
    exp_done = 1'b1; exp_err = 1'b0; exp_code = 0; exp_stage = 0;
    for (int i = 0; i < N; i++) begin
      if (m_en[i]) begin
        bit responds;
        exp_q.push_back(i);
        responds = (mode[i] != 2) && (tmo == 0 || lat[i] <= tmo);
        if (!responds) begin
          exp_done = 1'b0; exp_err = 1'b1; exp_code = 2; exp_stage = i;
          break;
        end
        if (mode[i] == 1) begin
          exp_done = 1'b0; exp_err = 1'b1; exp_code = 1; exp_stage = i;
          break;
        end
      end
    end
  endtask

  task automatic launch();
    start_log.delete(); addr_log.delete(); mm_log.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_check(input string name);
    int c;
    c = 0;
    while (busy && c < 3000) begin step(); c++; end
    check({name, "/run_ends"}, 64'(busy), 64'(0));
    repeat (15) step();
    check({name, "/done"}, 64'(done), 64'(exp_done));
    check({name, "/error"}, 64'(error), 64'(exp_err));
    check({name, "/err_code"}, 64'(err_code), 64'(exp_code));
    check({name, "/err_stage"}, 64'(err_stage), 64'(exp_stage));
    check({name, "/n_starts"}, 64'(start_log.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < start_log.size(); j++) begin
      check({name, "/start_idx"}, 64'(start_log[j]), 64'(exp_q[j]));
      check({name, "/addr_a"}, addr_log[j], m_addr[exp_q[j]]);
      check({name, "/m_mult"}, 64'(mm_log[j]), 64'(m_mm[exp_q[j]]));
    end
  endtask

  typedef struct {
    logic [3:0] en;
    int         err_stg;
    int         hang_stg;
    int         lt;
    int         tmo;
    int         n_exp;
    logic [7:0] seq;
    bit         e_done;
    bit         e_err;
    int         e_code;
    int         e_stage;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b1111, -1, -1, 5, 0,  4, 8'hE4, 1'b1, 1'b0, 0, 0};
    vecs[1] = '{4'b0010, -1, -1, 5, 0,  1, 8'h01, 1'b1, 1'b0, 0, 0};
    vecs[2] = '{4'b0000, -1, -1, 5, 0,  0, 8'h00, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{4'b1111,  2, -1, 5, 0,  3, 8'h24, 1'b0, 1'b1, 1, 2};
    vecs[4] = '{4'b0001, -1,  0, 5, 10, 1, 8'h00, 1'b0, 1'b1, 2, 0};
    vecs[5] = '{4'b1010, -1,  3, 5, 8,  2, 8'h0D, 1'b0, 1'b1, 2, 3};
    vecs[6] = '{4'b1101, -1, -1, 5, 5,  3, 8'h38, 1'b1, 1'b0, 0, 0};
    vecs[7] = '{4'b0100, -1, -1, 5, 4,  1, 8'h02, 1'b0, 1'b1, 2, 2};
    for (int i = 0; i < N; i++) begin mode[i] = 0; lat[i] = 5; cnt[i] = 0; end
    clear_model();

    // Reset state
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/done", 64'(done), 64'(0));
    check("rst/error", 64'(error), 64'(0));
    check("rst/err_code", 64'(err_code), 64'(0));
    check("rst/cur_stage", 64'(cur_stage), 64'(0));
    check("rst/stage_start", 64'(stage_start), 64'(0));
    check("rst/addr_a", addr_a, 64'(0));
    check("rst/m_g", 64'(m_g), 64'(0));

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      logic [7:0] sq;
      for (int i = 0; i < N; i++) begin
        mode[i] = (i == vecs[v].err_stg) ? 1 : (i == vecs[v].hang_stg) ? 2 : 0;
        lat[i]  = vecs[v].lt;
        write_entry(i, vecs[v].en[i], 1'b1);
      end
      timeout_cycles = TW'(vecs[v].tmo);
      exp_q.delete();
      sq = vecs[v].seq;
      for (int j = 0; j < vecs[v].n_exp; j++) exp_q.push_back(int'(sq[2*j +: 2]));
      exp_done = vecs[v].e_done; exp_err = vecs[v].e_err;
      exp_code = vecs[v].e_code; exp_stage = vecs[v].e_stage;
      launch();
      finish_check($sformatf("vec%0d", v));
    end

    // Empty table finishes within N+2 cycles of the start pulse
    for (int i = 0; i < N; i++) begin mode[i] = 0; write_entry(i, 1'b0, 1'b1); end
    begin
      int c;
      launch();
      c = 1;
      while (!done && c < 20) begin step(); c++; end
      check("empty/latency_ok", 64'(c <= N + 2), 64'(1));
      check("empty/done", 64'(done), 64'(1));
      check("empty/n_starts", 64'(start_log.size()), 64'(0));
    end

    // Watchdog fires exactly 10 WAIT cycles after ISSUE
    mode[0] = 2;
    write_entry(0, 1'b1, 1'b1);
    timeout_cycles = TW'(10);
    begin
      int c;
      launch();
      c = 0;
      while (!stage_start[0] && c < 10) begin step(); c++; end
      check("tmo/issue", 64'(stage_start[0]), 64'(1));
      repeat (10) step();
      check("tmo/not_yet", 64'(error), 64'(0));
      check("tmo/busy_before", 64'(busy), 64'(1));
      step();
      check("tmo/fired", 64'(error), 64'(1));
      check("tmo/err_code", 64'(err_code), 64'(2));
      check("tmo/busy_after", 64'(busy), 64'(0));
    end

    // Disabled watchdog waits indefinitely; reset in WAIT clears everything
    timeout_cycles = '0;
    launch();
    repeat (200) step();
    check("hang/busy", 64'(busy), 64'(1));
    check("hang/error", 64'(error), 64'(0));
    check("hang/cur_stage", 64'(cur_stage), 64'(0));
    rst = 1'b1;
    step();
    check("midrst/busy", 64'(busy), 64'(0));
    check("midrst/stage_start", 64'(stage_start), 64'(0));
    check("midrst/addr_a", addr_a, 64'(0));
    check("midrst/m_mult", 64'(m_mult), 64'(0));
    check("midrst/error", 64'(error), 64'(0));
    rst = 1'b0;
    clear_model();

    // Fresh run after reset
    for (int i = 0; i < N; i++) begin mode[i] = 0; lat[i] = 3; write_entry(i, 1'b1, 1'b1); end
    build_expect(0);
    launch();
    finish_check("fresh");

    // Mid-run table write and start pulse are both dropped
    for (int i = 0; i < N; i++) lat[i] = 5;
    launch();
    repeat (6) step();
    write_entry(3, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    build_expect(0);
    finish_check("midrun");

    // Randomized runs against the outcome model
    for (int r = 0; r < 40; r++) begin
      int tmo;
      tmo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 12));
      for (int i = 0; i < N; i++) begin
        int k;
        k = int'($urandom_range(0, 9));
        mode[i] = (k < 7) ? 0 : (k < 9) ? 1 : 2;
        if (tmo == 0 && mode[i] == 2) mode[i] = 0;
        lat[i] = int'($urandom_range(1, 12));
        write_entry(i, 1'($urandom_range(0, 1)), 1'b1);
      end
      timeout_cycles = TW'(tmo);
      build_expect(tmo);
      launch();
      finish_check($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ibert_stage_sequencer.md
Name: ibert_stage_sequencer

Overview:
Top-level run controller for the I-BERT encoder datapath. It holds a small per-stage configuration table with DDR base addresses and requant parameters. On one start pulse it runs the enabled stages in index order, for example attention, intermediate (matmul+GELU) and output. For each stage it drives the shared addr/requant buses, issues a start pulse, then waits for that stage's done or error, with a watchdog timeout. It sits between the control/CIPS register interface and the noc_*_top stage instances.

Parameters:
N_STAGES, 4, number of sequenced stages. Stage index width SW = $clog2(N_STAGES), minimum 1.
TIMEOUT_W, 32, width of the watchdog counter and limit.
ADDR_W, 64, DDR address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  write the config table entry at cfg_idx
cfg_idx  in  SW  entry index
cfg_en  in  1  stage enable bit
cfg_addr_a / cfg_addr_k / cfg_addr_g  in  ADDR_W each  base addresses
cfg_m_mult, cfg_m_g  in  32 each  requant mantissas
cfg_e_mult, cfg_e_g  in  8 each  requant exponents
timeout_cycles  in  TIMEOUT_W  per-stage watchdog limit; 0 disables the watchdog
start  in  1  run request, pulse
busy  out  1  run in progress
done  out  1  run completed without fault, sticky
error  out  1  run aborted, sticky
err_code  out  2  0 none, 1 stage error, 2 timeout
err_stage  out  SW  index of the faulting stage
cur_stage  out  SW  stage currently issued or awaited
stage_start  out  N_STAGES  one-hot start pulse
stage_done  in  N_STAGES  per-stage done, level or pulse
stage_error  in  N_STAGES  per-stage error
addr_A / addr_K / addr_G  out  ADDR_W each  shared stage address bus
requant_m_mult, requant_m_G  out  32 each  shared requant mantissas
requant_e_mult, requant_e_G  out  8 each  shared requant exponents

Behaviour:
- Reset: all outputs 0, including the shared buses. All table entries are cleared with en=0. State is IDLE.
- Table writes:
  - Accepted only in IDLE, DONE or FAULT.
  - cfg_we while busy is silently dropped.
  - cfg_idx >= N_STAGES is ignored.
- States: IDLE, SCAN, ISSUE, WAIT, DONE, FAULT.
- Starting a run:
  - start is honoured in IDLE, DONE or FAULT; it is ignored while busy.
  - Accepting start clears done, error, err_code and err_stage, sets busy, loads cur_stage=0 and enters SCAN.
- SCAN (1 cycle per entry):
  - If entry cur_stage is enabled, latch its fields onto the shared buses and go to ISSUE.
  - Otherwise increment cur_stage.
  - After the last index, go to DONE. A run with no enabled stage reaches DONE with no stage_start ever asserted.
- ISSUE (exactly 1 cycle):
  - stage_start[cur_stage]=1.
  - Clear the watchdog counter and go to WAIT.
  - The shared buses stay stable from the ISSUE cycle until the stage's completion is sampled.
- WAIT, evaluated in this priority order:
  1. stage_error[cur_stage] -> FAULT, err_code=1.
  2. stage_done[cur_stage] -> increment cur_stage and go to SCAN; go to DONE instead if cur_stage was the last index.
  3. Watchdog enabled and counter == timeout_cycles-1 -> FAULT, err_code=2.
  4. Otherwise increment the counter.
- WAIT sampling rules:
  - Error wins over a simultaneous done.
  - done/error of stages other than cur_stage are ignored.
  - stage_done already high during the ISSUE cycle is not sampled; the first sampling cycle is the first WAIT cycle.
- DONE: busy=0, done=1. Shared buses hold their last values.
- FAULT: busy=0, error=1, err_stage=cur_stage. No further stage_start is issued.
- stage_start is asserted only in ISSUE; it is never asserted in two consecutive cycles.
- rst asserted mid-run returns to the reset state on the next edge. Any pending stage_start is dropped.
- Watchdog counter saturates and never wraps.

Test Plan:
- Entries 0..3 enabled with distinct addresses; start; each stage asserts done 5 cycles after its stage_start -> stage_start sequence 0001, 0010, 0100, 1000; addr_A equals the entry value while each start is high; done=1 and error=0 at the end.
- Only entry 1 enabled -> exactly one stage_start (0010); every other start bit stays 0; done=1.
- No entry enabled; start -> done=1 within N_STAGES+2 cycles; stage_start stays 0.
- Entry 2 raises stage_error and stage_done in the same cycle -> error=1, err_code=1, err_stage=2; stage 3 is never started.
- timeout_cycles=10 and stage 0 never responds -> FAULT exactly 10 WAIT cycles after ISSUE with err_code=2; with timeout_cycles=0 the controller waits indefinitely.
- cfg_we and start pulsed mid-run are both ignored (table unchanged, run order unchanged); rst asserted during WAIT gives all outputs 0 on the next cycle and a fresh start runs normally.
